jtpang_objdma: RTL and testbench



---
 rtl/jtpang_objdma_pkg.sv | 15 +
 rtl/jtpang_objdma_edge.sv | 39 +++
 rtl/jtpang_objdma.sv | 171 +++++++++++++++++
 tb/tb_jtpang_objdma.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_objdma_pkg.sv
// rtl/jtpang_objdma_pkg.sv - shared types and constants for the object DMA engine
package jtpang_objdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Wide enough for read latencies 1..7
    localparam int CNT_W = 3;

endpackage

// File: rtl/jtpang_objdma_edge.sv
// rtl/jtpang_objdma_edge.sv - rising-edge detector with a single-deep pending latch
module jtpang_objdma_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    input  logic hold_i,
    input  logic clr_i,
    output logic rise_o,
    output logic pending_o
);

    logic sig_q;
    logic pend_q;
    logic pend_d;

    assign rise_o    = sig_i & ~sig_q;
    assign pending_o = pend_q;

    // Clear wins so an edge landing on the consuming cycle is left to the owner
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end else if (rise_o && hold_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/jtpang_objdma.sv
// rtl/jtpang_objdma.sv - object table DMA into the object line double buffer
// Optional running checksum of the last completed copy: JTPANG_OBJDMA_CHKSUM_EN
module jtpang_objdma
    import jtpang_objdma_pkg::*;
#(
    parameter int             AW     = 9,
    parameter int             RD_LAT = 2,
    parameter logic [AW-1:0]  BASE   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_dout,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we,
    output logic          obj_bank,
    output logic          busy,
    output logic [7:0]    chksum
);

    localparam logic [AW-1:0]    LAST   = '1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busrq_n_q, busrq_n_d;
    logic             we_q, we_d;
    logic [AW-1:0]    oaddr_q, oaddr_d;
    logic [7:0]       odin_q, odin_d;
    logic             bank_q, bank_d;
    logic             go_rise;
    logic             go_pend;
    logic             pend_clr;

    jtpang_objdma_edge u_go_edge (
        .clk       (clk),
        .rst       (rst),
        .sig_i     (dma_go),
        .hold_i    (state_q != ST_IDLE),
        .clr_i     (pend_clr),
        .rise_o    (go_rise),
        .pending_o (go_pend)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        oaddr_d   = oaddr_q;
        odin_d    = odin_q;
        bank_d    = bank_q;
        pend_clr  = 1'b0;
        busrq_n_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (go_rise) state_d = ST_REQ;
            end
            ST_REQ: begin
                idx_d = '0;
                cnt_d = '0;
                if (cen && !busak_n) state_d = ST_READ;
            end
            ST_READ: begin
                // CPU taking the bus back abandons the copy; the shown half is untouched
                if (busak_n) begin
                    state_d  = ST_IDLE;
                    pend_clr = 1'b1;
                end else if (cnt_q == LAT_M1) begin
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    oaddr_d = idx_q;
                    odin_d  = ram_dout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (busak_n) begin
                    state_d  = ST_IDLE;
                    pend_clr = 1'b1;
                end else if (cen) begin
                    if (idx_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        cnt_d   = '0;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                bank_d   = ~bank_q;
                idx_d    = '0;
                pend_clr = 1'b1;
                state_d  = (go_pend || go_rise) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busrq_n_d = !((state_d == ST_REQ) || (state_d == ST_READ) || (state_d == ST_WRITE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            busrq_n_q <= 1'b1;
            we_q      <= 1'b0;
            oaddr_q   <= '0;
            odin_q    <= '0;
            bank_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busrq_n_q <= busrq_n_d;
            we_q      <= we_d;
            oaddr_q   <= oaddr_d;
            odin_q    <= odin_d;
            bank_q    <= bank_d;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign busy     = (state_q != ST_IDLE);
    assign ram_addr = BASE + idx_q;
    assign obj_addr = oaddr_q;
    assign obj_din  = odin_q;
    assign obj_we   = we_q;
    assign obj_bank = bank_q;

`ifdef JTPANG_OBJDMA_CHKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] chk_q, chk_d;

    // The accumulator already holds the final byte by the time DONE is reached
    always_comb begin
        acc_d = acc_q;
        chk_d = chk_q;
        if (state_q == ST_REQ) begin
            acc_d = '0;
        end else if (we_q) begin
            acc_d = acc_q + odin_q;
        end
        if (state_q == ST_DONE) chk_d = acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            chk_q <= '0;
        end else begin
            acc_q <= acc_d;
            chk_q <= chk_d;
        end
    end

    assign chksum = chk_q;
`else
    assign chksum = 8'h00;
`endif

endmodule

// File: tb/tb_jtpang_objdma.sv
// tb/tb_jtpang_objdma.sv - scoreboard bench for the object DMA engine
module tb_jtpang_objdma;

    localparam int N = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen = 1'b1;
    logic       dma_go;
    logic       busak_n = 1'b1;
    logic       busrq_n;
    logic [8:0] ram_addr;
    logic [7:0] ram_dout;
    logic [8:0] obj_addr;
    logic [7:0] obj_din;
    logic       obj_we;
    logic       obj_bank;
    logic       busy;
    logic [7:0] chksum;

    jtpang_objdma #(.AW(9), .RD_LAT(2), .BASE(9'h000)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .dma_go   (dma_go),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .obj_addr (obj_addr),
        .obj_din  (obj_din),
        .obj_we   (obj_we),
        .obj_bank (obj_bank),
        .busy     (busy),
        .chksum   (chksum)
    );

    always #5 clk = ~clk;

    // Shared RAM with two clocks of read latency
    logic [7:0] mem [N];
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int   n_chk = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;
    bit   cen_rand = 1'b0;
    bit   steal = 1'b0;
    int   wcnt = 0;
    logic       exp_bank = 1'b0;
    logic [7:0] exp_chk = 8'h00;
    logic [17:0] sb_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // CPU bus model: grants five clocks after a request, releases on demand
    always @(negedge clk) begin
        #1;
        cen = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (busrq_n) begin
            busak_n = 1'b1;
            wcnt    = 0;
        end else if (steal) begin
            busak_n = 1'b1;
        end else if (wcnt == 5) begin
            busak_n = 1'b0;
        end else begin
            wcnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && obj_we) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'(1), 32'(0));
            end else begin
                check_val("obj_write", 32'({obj_bank, obj_addr, obj_din}), 32'(sb_q.pop_front()));
            end
        end
    end

    function automatic logic [7:0] mem_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < N; i++) s = s + mem[i];
        return s;
    endfunction

    task automatic push_copy(input logic bank);
        for (int i = 0; i < N; i++) sb_q.push_back({bank, 9'(i), mem[i]});
    endtask

    task automatic set_exp_chk();
`ifdef JTPANG_OBJDMA_CHKSUM_EN
        exp_chk = mem_sum();
`else
        exp_chk = 8'h00;
`endif
    endtask

    task automatic wait_wr(input int idx, input string tag);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(obj_we && obj_addr == 9'(idx)) && b < 8000);
        if (b >= 8000) check_val({tag, "_wait_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_idle(output int cyc, input string tag);
        int b = 0;
        cyc = 0;
        while (busy && b < 20000) begin
            cyc++;
            @(negedge clk);
            b++;
        end
        check_val({tag, "_timeout"}, 32'(b < 20000), 32'(1));
    endtask

    task automatic do_copy(input bit chk_lat, input string tag);
        int cyc;
        int w0;
        w0 = wr_cnt;
        push_copy(exp_bank);
        @(negedge clk);
        dma_go = 1'b1;
        @(negedge clk);
        dma_go = 1'b0;
        wait_idle(cyc, tag);
        exp_bank = ~exp_bank;
        set_exp_chk();
        check_val({tag, "_writes"}, 32'(wr_cnt - w0), 32'(N));
        check_val({tag, "_bank"}, 32'(obj_bank), 32'(exp_bank));
        check_val({tag, "_chksum"}, 32'(chksum), 32'(exp_chk));
        check_val({tag, "_busrq_n"}, 32'(busrq_n), 32'(1));
        check_val({tag, "_sb_left"}, 32'(sb_q.size()), 32'(0));
        if (chk_lat) check_val({tag, "_latency"}, 32'(cyc), 32'(5 + 1536 + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int w0;
        rst    = 1'b1;
        dma_go = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clk);
        check_val("rst_busrq_n", 32'(busrq_n), 32'(1));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_obj_we", 32'(obj_we), 32'(0));
        check_val("rst_obj_bank", 32'(obj_bank), 32'(0));
        check_val("rst_ram_addr", 32'(ram_addr), 32'(0));
        check_val("rst_obj_addr", 32'(obj_addr), 32'(0));
        check_val("rst_obj_din", 32'(obj_din), 32'(0));
        check_val("rst_chksum", 32'(chksum), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal copy with cen every clock, then with a sparse cen
        do_copy(1'b1, "nominal");
        cen_rand = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        do_copy(1'b0, "cen_rand");
        cen_rand = 1'b0;

        // Second edge becomes pending, third is dropped
        w0 = wr_cnt;
        push_copy(exp_bank);
        @(negedge clk); dma_go = 1'b1;
        @(negedge clk); dma_go = 1'b0;
        wait_wr(100, "pend_a");
        dma_go = 1'b1;
        push_copy(~exp_bank);
        @(negedge clk); dma_go = 1'b0;
        wait_wr(150, "pend_b");
        dma_go = 1'b1;
        @(negedge clk); dma_go = 1'b0;
        wait_idle(cyc, "pend");
        set_exp_chk();
        check_val("pend_writes", 32'(wr_cnt - w0), 32'(2 * N));
        check_val("pend_bank", 32'(obj_bank), 32'(exp_bank));
        check_val("pend_chksum", 32'(chksum), 32'(exp_chk));
        repeat (40) @(negedge clk);
        check_val("pend_third_dropped", 32'(busy), 32'(0));

        // CPU steals the bus back at index 200
        for (int i = 0; i < N; i++) mem[i] = 8'h11;
        w0 = wr_cnt;
        push_copy(exp_bank);
        @(negedge clk); dma_go = 1'b1;
        @(negedge clk); dma_go = 1'b0;
        wait_wr(200, "abort");
        steal = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_busrq_n", 32'(busrq_n), 32'(1));
        check_val("abort_idle", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
        check_val("abort_writes", 32'(wr_cnt - w0), 32'(201));
        check_val("abort_bank", 32'(obj_bank), 32'(exp_bank));
        check_val("abort_chksum", 32'(chksum), 32'(exp_chk));
        sb_q.delete();
        steal = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted during a write
        for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'hC3;
        push_copy(exp_bank);
        @(negedge clk); dma_go = 1'b1;
        @(negedge clk); dma_go = 1'b0;
        wait_wr(50, "rstmid");
        rst = 1'b1;
        #1;
        check_val("rstmid_busrq_n", 32'(busrq_n), 32'(1));
        check_val("rstmid_obj_we", 32'(obj_we), 32'(0));
        check_val("rstmid_busy", 32'(busy), 32'(0));
        check_val("rstmid_bank", 32'(obj_bank), 32'(0));
        check_val("rstmid_chksum", 32'(chksum), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        exp_bank = 1'b0;
        repeat (3) @(negedge clk);
        do_copy(1'b1, "restart");

        // Checksum patterns
        for (int i = 0; i < N; i++) mem[i] = 8'h01;
        do_copy(1'b0, "chk_ones");
        for (int i = 0; i < N; i++) mem[i] = 8'h03;
        do_copy(1'b0, "chk_threes");
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        mem[0] = 8'h07;
        do_copy(1'b0, "chk_first7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
